corr_readout_sched: RTL and testbench

Sequences result readout from up to `N_CORR` spread-spectrum correlators on the shared 32-bit register bus.
- Watches the per-correlator `seen` flags and picks one correlator at a time, round-robin.
- Reads that correlator's Cnt, Low, High and Status registers. The Status read clears its `seen` flag.
- Emits one packed result on a valid/ready stream.
- Sits between the host bus master and the correlator register file. The host always has priority on the bus.

---
 rtl/corr_pkg.sv | 39 +++
 rtl/corr_readout_sched_rr_pick.sv | 33 +++
 rtl/corr_readout_sched.sv | 185 ++++++++++++++++++
 tb/tb_corr_readout_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared definitions for the correlator readout sequencer.
// Holds the sequencer state encoding, the register offsets inside one
// correlator register group, the packed result record and the
// round-robin pointer advance helper.
package corr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_CNT  = 3'd1,
      ST_RD_LOW  = 3'd2,
      ST_RD_HIGH = 3'd3,
      ST_RD_STAT = 3'd4,
      ST_OUT     = 3'd5
   } state_e;

   localparam logic [31:0] CNT_OFS  = 32'h0000_0000;
   localparam logic [31:0] LOW_OFS  = 32'h0000_0004;
   localparam logic [31:0] HIGH_OFS = 32'h0000_0008;
   localparam logic [31:0] STAT_OFS = 32'h0000_000C;

   typedef struct packed {
      logic [4:0]  id;
      logic [31:0] cnt;
      logic [63:0] corr;
      logic        stat;
   } result_t;

   // Index following idx, wrapping at n (n correlators).
   function automatic logic [4:0] rr_next(input logic [4:0] idx, input int n);
      logic [4:0] nxt;
      if (int'(idx) >= n - 1) begin
         nxt = 5'd0;
      end else begin
         nxt = idx + 5'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/corr_readout_sched_rr_pick.sv
// Combinational round-robin first-set finder.
// Ports:
//   req   [N-1:0] request flags
//   ptr   [4:0]   search start index (must be < N)
//   found         at least one request flag is set
//   idx   [4:0]   first set flag at or above ptr, wrapping modulo N
module rr_pick #(
   parameter int N = 32
) (
   input  logic [N-1:0] req,
   input  logic [4:0]   ptr,
   output logic         found,
   output logic [4:0]   idx
);

   int  j;
   logic hit;

   // Scan N positions starting at ptr; the first hit freezes idx.
   always_comb begin
      found = 1'b0;
      idx   = 5'd0;
      j     = 0;
      hit   = 1'b0;
      for (int i = 0; i < N; i++) begin
         j     = (int'(ptr) + i) % N;
         hit   = !found && req[j];
         idx   = hit ? 5'(j) : idx;
         found = found | hit;
      end
   end

endmodule

// File: rtl/corr_readout_sched.sv
// Correlator result readout sequencer.
// Picks correlators with a pending seen flag in round-robin order, reads
// their Cnt, Low, High and Status registers over the shared bus (the
// Status read clears the flag inside the correlator) and presents one
// packed result on a valid/ready stream. The host master always wins the
// shared bus; a sequencer read cycle lost to the host is simply retried.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              allows a new sequence to start
//   seen[N_CORR-1:0]    per-correlator seen flags
//   h_*                 host master side (h_rdata mirrors m_rdata)
//   m_*                 shared register bus (m_rdata same-cycle)
//   res_*               result stream, held stable until res_ready
module corr_readout_sched
   import corr_pkg::*;
#(
   parameter int          N_CORR    = 32,
   parameter logic [31:0] CORR_BASE = 32'hFE00_0700,
   parameter int          STRIDE    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [N_CORR-1:0] seen,
   input  logic [31:0]       h_addr,
   input  logic [31:0]       h_wdata,
   input  logic              h_write,
   input  logic              h_read,
   output logic [31:0]       h_rdata,
   output logic [31:0]       m_addr,
   output logic [31:0]       m_wdata,
   output logic              m_write,
   output logic              m_read,
   input  logic [31:0]       m_rdata,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [4:0]        res_id,
   output logic [31:0]       res_cnt,
   output logic [63:0]       res_corr,
   output logic              res_stat
);

   state_e      state_q, state_d;
   logic [4:0]  sel_q, sel_d;
   logic [4:0]  ptr_q, ptr_d;
   result_t     res_q, res_d;
   logic        valid_q, valid_d;

   logic        host_s;
   logic        found_s;
   logic [4:0]  idx_s;
   logic        seq_read_s;
   logic [31:0] ofs_s;
   logic [31:0] seq_addr_s;

   assign host_s = h_read | h_write;

   rr_pick #(.N(N_CORR)) u_pick (
      .req   (seen),
      .ptr   (ptr_q),
      .found (found_s),
      .idx   (idx_s)
   );

   // Register offset and read request for the current read state.
   always_comb begin
      ofs_s      = CNT_OFS;
      seq_read_s = 1'b1;
      case (state_q)
         ST_RD_CNT:  ofs_s = CNT_OFS;
         ST_RD_LOW:  ofs_s = LOW_OFS;
         ST_RD_HIGH: ofs_s = HIGH_OFS;
         ST_RD_STAT: ofs_s = STAT_OFS;
         default:    seq_read_s = 1'b0;
      endcase
   end

   assign seq_addr_s = CORR_BASE + (32'(STRIDE) * {27'd0, sel_q}) + ofs_s;

   // Shared-bus mux: the host owns the bus whenever it strobes.
   always_comb begin
      m_addr  = seq_addr_s;
      m_wdata = 32'd0;
      m_write = 1'b0;
      m_read  = seq_read_s;
      if (host_s) begin
         m_addr  = h_addr;
         m_wdata = h_wdata;
         m_write = h_write;
         m_read  = h_read;
      end else begin
         m_read  = seq_read_s;
      end
   end

   assign h_rdata = m_rdata;

   // Next-state logic; a read state only captures and advances when the
   // host left the bus to the sequencer this cycle.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && found_s) begin
               sel_d    = idx_s;
               res_d.id = idx_s;
               state_d  = ST_RD_CNT;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RD_CNT: begin
            if (!host_s) begin
               res_d.cnt = m_rdata;
               state_d   = ST_RD_LOW;
            end else begin
               state_d   = ST_RD_CNT;
            end
         end
         ST_RD_LOW: begin
            if (!host_s) begin
               res_d.corr[31:0] = m_rdata;
               state_d          = ST_RD_HIGH;
            end else begin
               state_d          = ST_RD_LOW;
            end
         end
         ST_RD_HIGH: begin
            if (!host_s) begin
               res_d.corr[63:32] = m_rdata;
               state_d           = ST_RD_STAT;
            end else begin
               state_d           = ST_RD_HIGH;
            end
         end
         ST_RD_STAT: begin
            if (!host_s) begin
               res_d.stat = m_rdata[0];
               state_d    = ST_OUT;
            end else begin
               state_d    = ST_RD_STAT;
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               // Advancing past sel keeps one busy correlator from
               // starving the others.
               ptr_d   = rr_next(sel_q, N_CORR);
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_OUT);
   end

   // State, pointer and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 5'd0;
         ptr_q   <= 5'd0;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign res_valid = valid_q;
   assign res_id    = res_q.id;
   assign res_cnt   = res_q.cnt;
   assign res_corr  = res_q.corr;
   assign res_stat  = res_q.stat;

endmodule

// File: tb/tb_corr_readout_sched.sv
// Self-checking bench for corr_readout_sched: correlator register-file
// model on the bus, transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_corr_readout_sched;

   localparam int          N    = 32;
   localparam logic [31:0] BASE = 32'hFE00_0700;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] seen;
   logic [31:0] h_addr = 32'd0, h_wdata = 32'd0;
   logic        h_write = 1'b0, h_read = 1'b0;
   logic [31:0] h_rdata, m_addr, m_wdata, m_rdata;
   logic        m_write, m_read;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [4:0]  res_id;
   logic [31:0] res_cnt;
   logic [63:0] res_corr;
   logic        res_stat;

   int checks = 0;
   int failures = 0;

   // correlator register file model
   logic [31:0] cnt_mem [N];
   logic [31:0] low_mem [N];
   logic [31:0] high_mem[N];
   logic [31:0] stat_mem[N];
   logic [31:0] seen_q = 32'd0;
   logic [31:0] seen_set = 32'd0;
   logic [31:0] seen_force = 32'd0;
   logic [31:0] clr_mask;
   logic [31:0] boff;

   corr_readout_sched #(.N_CORR(N), .CORR_BASE(BASE), .STRIDE(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .seen(seen),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_write(h_write), .h_read(h_read),
      .h_rdata(h_rdata), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_write(m_write), .m_read(m_read), .m_rdata(m_rdata),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_cnt(res_cnt), .res_corr(res_corr), .res_stat(res_stat)
   );

   always #5 clk = ~clk;

   assign seen = seen_q | seen_set | seen_force;

   // Bus slave: correlator groups at BASE, anything else returns a pattern.
   always_comb begin
      boff     = m_addr - BASE;
      clr_mask = 32'd0;
      m_rdata  = m_addr ^ 32'hA5A5_5A5A;
      if (boff < 32'd512) begin
         case (boff[3:2])
            2'd0:    m_rdata = cnt_mem[boff[8:4]];
            2'd1:    m_rdata = low_mem[boff[8:4]];
            2'd2:    m_rdata = high_mem[boff[8:4]];
            default: m_rdata = stat_mem[boff[8:4]];
         endcase
         if (m_read && boff[3:2] == 2'd3) clr_mask[boff[8:4]] = 1'b1;
      end
   end

   // A Status read clears the correlator's flag from the next cycle on.
   always @(posedge clk) seen_q <= (seen_q | seen_set) & ~clr_mask;

   // ---------------- reference model (transaction level) ----------------
   int          mph = 0;   // 0 waiting, 1..4 = register being read, 5 result
   int          msel = 0, mptr = 0;
   logic [31:0] mcnt = 32'd0;
   logic [63:0] mcorr = 64'd0;
   logic        mstat = 1'b0;

   function automatic int pick(input logic [31:0] s, input int p);
      for (int i = 0; i < N; i++) begin
         if (s[(p + i) % N]) return (p + i) % N;
      end
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mph <= 0; msel <= 0; mptr <= 0;
         mcnt <= 32'd0; mcorr <= 64'd0; mstat <= 1'b0;
      end else if (mph == 0) begin
         if (enable && seen != 32'd0) begin
            msel <= pick(seen, mptr);
            mph  <= 1;
         end
      end else if (mph <= 4) begin
         if (!(h_read | h_write)) begin
            if (mph == 1) mcnt <= cnt_mem[msel];
            if (mph == 2) mcorr[31:0] <= low_mem[msel];
            if (mph == 3) mcorr[63:32] <= high_mem[msel];
            if (mph == 4) mstat <= stat_mem[msel][0];
            mph <= mph + 1;
         end
      end else if (res_ready) begin
         mptr <= (msel + 1) % N;
         mph  <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (!rst) begin
         logic        host, exp_rd;
         logic [31:0] exp_addr;
         host     = h_read | h_write;
         exp_rd   = host ? h_read : (mph >= 1 && mph <= 4);
         exp_addr = host ? h_addr : BASE + 32'(16 * msel + 4 * (mph - 1));
         chk("res_valid", 64'(res_valid), 64'(mph == 5));
         if (mph == 5) begin
            chk("res_id", 64'(res_id), 64'(msel));
            chk("res_cnt", 64'(res_cnt), 64'(mcnt));
            chk("res_corr", res_corr, mcorr);
            chk("res_stat", 64'(res_stat), 64'(mstat));
         end
         chk("m_read", 64'(m_read), 64'(exp_rd));
         if (exp_rd) chk("m_addr", 64'(m_addr), 64'(exp_addr));
         chk("m_write", 64'(m_write), 64'(host ? h_write : 1'b0));
         if (host) chk("m_wdata", 64'(m_wdata), 64'(h_wdata));
         chk("h_rdata", 64'(h_rdata), 64'(m_rdata));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cyc, input int limit);
      cyc = 0;
      while (!res_valid && cyc < limit) begin
         tick();
         cyc++;
      end
      if (!res_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (!(mph == 0 && seen == 32'd0) && c < 400) begin
         tick();
         c++;
      end
      if (c >= 400) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int          c;
      int          ids[4];
      logic [4:0]  hid;
      logic [31:0] hcnt;
      logic [63:0] hcorr;
      logic        stable;

      for (int k = 0; k < N; k++) begin
         cnt_mem[k]  = $urandom | 32'd1;
         low_mem[k]  = $urandom;
         high_mem[k] = $urandom;
         stat_mem[k] = $urandom;
      end
      cnt_mem[4] = 32'h0000_0123; low_mem[4] = 32'hDEAD_BEEF;
      high_mem[4] = 32'h0000_0001; stat_mem[4] = 32'h0000_0001;

      // reset values
      #12;
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_id", 64'(res_id), 64'd0);
      chk("rst_cnt", 64'(res_cnt), 64'd0);
      chk("rst_corr", res_corr, 64'd0);
      chk("rst_stat", 64'(res_stat), 64'd0);
      chk("rst_mread", 64'(m_read), 64'd0);
      chk("rst_mwrite", 64'(m_write), 64'd0);
      tick();
      rst = 1'b0;
      enable = 1'b1;
      tick();

      // single flag, literal addresses and result
      seen_set = 32'h0000_0010;
      tick(); seen_set = 32'd0; #2;
      chk("t1_rd_cnt", 64'({m_read, m_addr}), 64'({1'b1, 32'hFE00_0740}));
      tick(); #2;
      chk("t1_rd_low", 64'({m_read, m_addr}), 64'({1'b1, 32'hFE00_0744}));
      tick(); #2;
      chk("t1_rd_high", 64'({m_read, m_addr}), 64'({1'b1, 32'hFE00_0748}));
      tick(); #2;
      chk("t1_rd_stat", 64'({m_read, m_addr}), 64'({1'b1, 32'hFE00_074C}));
      tick();
      chk("t1_valid", 64'(res_valid), 64'd1);
      chk("t1_id", 64'(res_id), 64'd4);
      chk("t1_corr", res_corr, 64'h0000_0001_DEAD_BEEF);
      chk("t1_cnt", 64'(res_cnt), 64'h123);
      chk("t1_stat", 64'(res_stat), 64'd1);
      drain();

      // round robin from ptr 0 with two flags held
      rst = 1'b1; tick(); rst = 1'b0; tick();
      seen_force = 32'h8000_0001;
      for (int r = 0; r < 4; r++) begin
         wait_valid(c, 20);
         ids[r] = int'(res_id);
         if (r == 3) seen_force = 32'd0;
         tick();
      end
      chk("rr_0", 64'(ids[0]), 64'd0);
      chk("rr_1", 64'(ids[1]), 64'd31);
      chk("rr_2", 64'(ids[2]), 64'd0);
      chk("rr_3", 64'(ids[3]), 64'd31);
      drain();

      // host collision in RD_LOW for 3 cycles
      seen_set = 32'h0000_0010;
      tick(); seen_set = 32'd0;
      tick();
      h_read = 1'b1; h_addr = 32'h0000_1000; #2;
      chk("hc_rdata", 64'(h_rdata), 64'hA5A5_4A5A);
      tick(); tick(); tick();
      h_read = 1'b0;
      wait_valid(c, 20);
      chk("hc_latency", 64'(c + 5), 64'd8);
      chk("hc_corr", res_corr, 64'h0000_0001_DEAD_BEEF);
      chk("hc_cnt", 64'(res_cnt), 64'h123);
      drain();

      // backpressure for 10 cycles with another flag pending
      res_ready = 1'b0;
      seen_set = 32'h0000_0280;
      tick(); seen_set = 32'd0;
      wait_valid(c, 20);
      hid = res_id; hcnt = res_cnt; hcorr = res_corr;
      chk("bp_id", 64'(hid), 64'd7);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!res_valid || m_read || res_id != hid || res_cnt != hcnt || res_corr != hcorr)
            stable = 1'b0;
      end
      chk("bp_stable", 64'(stable), 64'd1);
      res_ready = 1'b1;
      tick();
      chk("bp_handshake", 64'(res_valid), 64'd0);
      drain();

      // enable dropped in RD_HIGH
      seen_force = 32'h0000_0004;
      tick(); tick(); tick();
      enable = 1'b0;
      wait_valid(c, 20);
      chk("en_id", 64'(res_id), 64'd2);
      tick();
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_read || res_valid) stable = 1'b0;
      end
      chk("en_no_restart", 64'(stable), 64'd1);
      seen_force = 32'd0;
      enable = 1'b1;
      drain();

      // reset in RD_HIGH
      seen_set = 32'h0000_1000;
      tick(); seen_set = 32'd0;
      tick(); tick();
      rst = 1'b1; #1;
      chk("rr_rst_valid", 64'(res_valid), 64'd0);
      chk("rr_rst_mread", 64'(m_read), 64'd0);
      chk("rr_rst_cnt", 64'(res_cnt), 64'd0);
      chk("rr_rst_corr", res_corr, 64'd0);
      tick();
      rst = 1'b0;
      chk("rr_seen_kept", 64'(seen[12]), 64'd1);
      wait_valid(c, 20);
      chk("rr_reread_lat", 64'(c), 64'd5);
      chk("rr_reread_id", 64'(res_id), 64'd12);
      chk("rr_reread_corr", res_corr, {high_mem[12], low_mem[12]});
      tick();
      drain();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         seen_set  = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, N - 1)) : 32'd0;
         enable    = ($urandom_range(0, 15) != 0);
         res_ready = ($urandom_range(0, 3) != 0);
         h_read    = 1'b0;
         h_write   = 1'b0;
         case ($urandom_range(0, 7))
            0: h_read = 1'b1;
            1: h_write = 1'b1;
            default: ;
         endcase
         h_addr  = $urandom & 32'h0000_FFFC;
         h_wdata = $urandom;
      end
      tick();
      seen_set = 32'd0; h_read = 1'b0; h_write = 1'b0;
      enable = 1'b1; res_ready = 1'b1;
      drain();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
